// File: rtl/mem_bus_pkg.sv
// Shared encodings for the two-master memory bus arbiter.
// State and master ids used by the arbiter and its round-robin picker.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/bus_rr_select.sv
// Two-way round-robin picker.
// On a tie the master that was not served last wins.
module bus_rr_select
    import mem_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       id
);

    always_comb begin
        valid = |req;
        id    = M0;
        unique case (1'b1)
            (&req):             id = ~last;
            (req[1] & ~req[0]): id = M1;
            default:            id = M0;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the decoder master port between
// the core memory port (M0) and the UART loader (M1).
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_LENGTH = 32,
    parameter int DATA_LENGTH = 32,
    parameter int RD_LATENCY  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   m0_req,
    input  logic                   m0_we,
    input  logic [ADDR_LENGTH-1:0] m0_addr,
    input  logic [DATA_LENGTH-1:0] m0_wdata,
    output logic                   m0_gnt,
    output logic                   m0_done,
    output logic [DATA_LENGTH-1:0] m0_rdata,
    input  logic                   m1_req,
    input  logic                   m1_we,
    input  logic [ADDR_LENGTH-1:0] m1_addr,
    input  logic [DATA_LENGTH-1:0] m1_wdata,
    output logic                   m1_gnt,
    output logic                   m1_done,
    output logic [DATA_LENGTH-1:0] m1_rdata,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic [ADDR_LENGTH-1:0] AddrOut,
    output logic [DATA_LENGTH-1:0] DataOut,
    input  logic [DATA_LENGTH-1:0] DataIn
);

    localparam logic [2:0] LAST_CNT = 3'(RD_LATENCY - 1);

    state_t     state;
    logic [2:0] wait_cnt;
    logic       gnt_id;
    logic       last_gnt;
    logic       we_q;
    logic       pick_valid;
    logic       pick_id;
    logic       pick_we;

    bus_rr_select u_rr_select (
        .req   ({m1_req, m0_req}),
        .last  (last_gnt),
        .valid (pick_valid),
        .id    (pick_id)
    );

    assign pick_we = (pick_id == M1) ? m1_we : m0_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            gnt_id   <= M0;
            last_gnt <= M1;
            we_q     <= 1'b0;
            m0_gnt   <= 1'b0;
            m1_gnt   <= 1'b0;
            m0_done  <= 1'b0;
            m1_done  <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            AddrOut  <= '0;
            DataOut  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state    <= ACCESS;
                        gnt_id   <= pick_id;
                        we_q     <= pick_we;
                        wait_cnt <= '0;
                        AddrOut  <= (pick_id == M1) ? m1_addr : m0_addr;
                        DataOut  <= (pick_id == M1) ? m1_wdata : m0_wdata;
                        MemRead  <= ~pick_we;
                        MemWrite <= pick_we;
                        m0_gnt   <= (pick_id == M0);
                        m1_gnt   <= (pick_id == M1);
                    end
                end
                ACCESS: begin
                    // a write strobes once; the slave must not see a repeat
                    MemWrite <= 1'b0;
                    if (wait_cnt == LAST_CNT) begin
                        state   <= DONE;
                        MemRead <= 1'b0;
                        m0_done <= (gnt_id == M0);
                        m1_done <= (gnt_id == M1);
                        if (!we_q && gnt_id == M0) m0_rdata <= DataIn;
                        if (!we_q && gnt_id == M1) m1_rdata <= DataIn;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    last_gnt <= gnt_id;
                    m0_done  <= 1'b0;
                    m1_done  <= 1'b0;
                    m0_gnt   <= 1'b0;
                    m1_gnt   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
